// File: rtl/qsys_pio_in_edge.sv
// Avalon-MM input PIO: input synchroniser, per-bit debounce, edge capture
// with write-1-to-clear and a maskable, registered level interrupt.
module qsys_pio_in_edge #(
    parameter int unsigned      WIDTH        = 18,
    parameter int unsigned      SYNC_STAGES  = 2,
    parameter int unsigned      DEBOUNCE_CYC = 1,
    parameter int unsigned      EDGE_TYPE    = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [CNT_W-1:0] cnt_q  [WIDTH];
    logic [CNT_W-1:0] cnt_d  [WIDTH];
    logic [WIDTH-1:0] data_db_q, data_db_d;
    logic [WIDTH-1:0] prev_db_q;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;

    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] edge_ev;
    logic [WIDTH-1:0] clr;
    logic             wr_en;
    logic             unused_wdata;

    assign sync_s       = sync_q[SYNC_STAGES-1];
    assign wr_en        = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    // Debounce: a bit follows the synchronised input only once it has
    // disagreed with the filtered value for DEBOUNCE_CYC consecutive cycles.
    always_comb begin
        data_db_d = data_db_q;
        for (int i = 0; i < WIDTH; i++) begin
            // NOTE: every combinational output gets a default first so no latch is inferred.
            cnt_d[i] = '0;
            if (sync_s[i] != data_db_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    data_db_d[i] = sync_s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        case (EDGE_TYPE)
            0:       edge_ev = data_db_q & ~prev_db_q;
            1:       edge_ev = ~data_db_q & prev_db_q;
            default: edge_ev = data_db_q ^ prev_db_q;
        endcase

        clr       = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
        irqmask_d = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : irqmask_q;
        // A new event on a bit being cleared in the same cycle survives.
        edgecap_d = (edgecap_q & ~clr) | edge_ev;
        irq_d     = |(edgecap_d & irqmask_d);

        readdata_d = '0;
        case (address)
            2'd0:    readdata_d[WIDTH-1:0] = data_db_q;
            2'd2:    readdata_d[WIDTH-1:0] = irqmask_q;
            2'd3:    readdata_d[WIDTH-1:0] = edgecap_q;
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the synchroniser and counter arrays are reset element by element so a reset mid-debounce abandons any partial count.
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            for (int i = 0; i < WIDTH; i++)       cnt_q[i]  <= '0;
            data_db_q  <= RESET_VALUE;
            prev_db_q  <= RESET_VALUE;
            edgecap_q  <= '0;
            irqmask_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every stage sampling the pre-edge value of its neighbour.
            sync_q[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            for (int i = 0; i < WIDTH; i++)       cnt_q[i]  <= cnt_d[i];
            data_db_q  <= data_db_d;
            prev_db_q  <= data_db_q;
            edgecap_q  <= edgecap_d;
            irqmask_q  <= irqmask_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_qsys_pio_in_edge.sv
// Bench for qsys_pio_in_edge: directed scenarios on four parameter sets plus
// a randomised run of the debounce instance against a window-based model.
module tb_qsys_pio_in_edge;

    localparam int M_SYNC = 2;
    localparam int M_DEB  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [17:0] in_a, in_b;
    logic [31:0] in_c;
    logic [0:0]  in_d;
    logic [31:0] rd_a, rd_b, rd_c, rd_d;
    logic        irq_a, irq_b, irq_c, irq_d;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    qsys_pio_in_edge #(.WIDTH(18)) u_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_a),
        .in_port(in_a), .irq(irq_a));

    qsys_pio_in_edge #(.WIDTH(18), .SYNC_STAGES(M_SYNC), .DEBOUNCE_CYC(M_DEB), .EDGE_TYPE(0)) u_b (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_b),
        .in_port(in_b), .irq(irq_b));

    qsys_pio_in_edge #(.WIDTH(32), .EDGE_TYPE(2)) u_c (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_c),
        .in_port(in_c), .irq(irq_c));

    qsys_pio_in_edge #(.WIDTH(1), .SYNC_STAGES(3), .EDGE_TYPE(1)) u_d (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_d),
        .in_port(in_d), .irq(irq_d));

    // Reference model of u_b: inputs delayed through a queue, a bit flips
    // when the last M_DEB delayed samples all disagree with it.
    logic [17:0] m_pipe [$];
    logic [17:0] m_win  [$];
    logic [17:0] m_db, m_prev, m_mask, m_ec;
    logic [31:0] m_rd;
    logic        m_irq;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [17:0] s, db_new, ev, clr, ec_new, mask_new;
        bit          wr, all_diff;
        if (reset) begin
            m_pipe = {};
            for (int i = 0; i < M_SYNC; i++) m_pipe.push_back(18'h0);
            m_win  = {};
            m_db   = '0;
            m_prev = '0;
            m_mask = '0;
            m_ec   = '0;
            m_rd   = '0;
            m_irq  = 1'b0;
        end else begin
            wr = chipselect && !write_n;
            case (address)
                2'd0:    m_rd = {14'h0, m_db};
                2'd2:    m_rd = {14'h0, m_mask};
                2'd3:    m_rd = {14'h0, m_ec};
                default: m_rd = '0;
            endcase
            ev       = m_db & ~m_prev;
            clr      = (wr && address == 2'd3) ? writedata[17:0] : 18'h0;
            mask_new = (wr && address == 2'd2) ? writedata[17:0] : m_mask;
            ec_new   = (m_ec & ~clr) | ev;
            s = m_pipe.pop_front();
            m_pipe.push_back(in_b);
            m_win.push_back(s);
            if (m_win.size() > M_DEB) void'(m_win.pop_front());
            db_new = m_db;
            if (m_win.size() == M_DEB) begin
                for (int b = 0; b < 18; b++) begin
                    all_diff = 1'b1;
                    foreach (m_win[k]) if (m_win[k][b] == m_db[b]) all_diff = 1'b0;
                    if (all_diff) db_new[b] = ~m_db[b];
                end
            end
            m_prev = m_db;
            m_db   = db_new;
            m_ec   = ec_new;
            m_mask = mask_new;
            m_irq  = |(ec_new & mask_new);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model_rd", rd_b, m_rd);
        check("model_irq", {31'h0, irq_b}, {31'h0, m_irq});
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    initial begin
        logic [17:0] flip;
        reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        in_a = 18'h3FFFF; in_b = 18'h3FFFF; in_c = '0; in_d = 1'b0;

        // Reset hold and release latency on the undebounced instance
        repeat (3) begin
            step();
            check("rst_rd", rd_a, 32'h0);
            check("rst_irq", {31'h0, irq_a}, 32'h0);
        end
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            check("rst_latency", rd_a, (k == 4) ? 32'h3FFFF : 32'h0);
        end
        in_a = '0; in_b = '0;
        wait_n(12);
        write_reg(2'd3, 32'hFFFF_FFFF);

        // Debounce: 3-cycle glitch rejected, 4-cycle pulse accepted
        address = 2'd0; in_b = 18'h1;
        for (int k = 1; k <= 11; k++) begin
            if (k == 4) in_b = 18'h0;
            step();
            check("glitch_rd", rd_b, 32'h0);
        end
        address = 2'd3;
        step();
        check("glitch_ec", rd_b, 32'h0);
        address = 2'd0; in_b = 18'h1;
        for (int k = 1; k <= 7; k++) begin
            if (k == 5) in_b = 18'h0;
            step();
            check("db_latency", rd_b, (k == 7) ? 32'h1 : 32'h0);
        end
        wait_n(8);
        address = 2'd3;
        step();
        check("db_ec", rd_b, 32'h1);
        write_reg(2'd3, 32'h1);
        step();
        check("clr_ec", rd_b, 32'h0);

        // Masked interrupt
        write_reg(2'd2, 32'h2);
        in_b = 18'h1;
        wait_n(10);
        address = 2'd3;
        step();
        check("irq_ec0", rd_b, 32'h1);
        check("irq_masked", {31'h0, irq_b}, 32'h0);
        in_b = 18'h3;
        wait_n(10);
        step();
        check("irq_ec1", rd_b, 32'h3);
        check("irq_set", {31'h0, irq_b}, 32'h1);
        write_reg(2'd3, 32'h2);
        check("irq_clr", {31'h0, irq_b}, 32'h0);
        step();
        check("irq_clr_ec", rd_b, 32'h1);

        // Clear colliding with a new event
        write_reg(2'd2, 32'h3);
        check("col_irq_pre", {31'h0, irq_b}, 32'h1);
        in_b = 18'h2;
        wait_n(10);
        in_b = 18'h3;
        wait_n(6);
        write_reg(2'd3, 32'h1);
        check("col_irq", {31'h0, irq_b}, 32'h1);
        step();
        check("col_ec", rd_b, 32'h1);
        write_reg(2'd3, 32'h1);
        check("nocol_irq", {31'h0, irq_b}, 32'h0);
        step();
        check("nocol_ec", rd_b, 32'h0);

        // Writes to data and reserved words have no effect
        write_reg(2'd0, 32'hFFFF_FFFF);
        write_reg(2'd1, 32'hFFFF_FFFF);
        address = 2'd2;
        step();
        check("mask_keep", rd_b, 32'h3);
        address = 2'd1;
        step();
        check("addr1_zero", rd_b, 32'h0);

        // Wide any-edge and narrow falling-edge variants
        write_reg(2'd3, 32'hFFFF_FFFF);
        in_c = 32'h8000_0001; in_d = 1'b1;
        wait_n(8);
        address = 2'd3;
        step();
        check("c_rise_ec", rd_c, 32'h8000_0001);
        check("d_rise_ec", rd_d, 32'h0);
        address = 2'd0;
        step();
        check("c_data", rd_c, 32'h8000_0001);
        check("d_data", rd_d, 32'h1);
        write_reg(2'd3, 32'hFFFF_FFFF);
        in_c = '0; in_d = 1'b0;
        wait_n(8);
        address = 2'd3;
        step();
        check("c_fall_ec", rd_c, 32'h8000_0001);
        check("d_fall_ec", rd_d, 32'h1);
        write_reg(2'd3, 32'hFFFF_FFFF);
        in_c = 32'h8000_0001; in_d = 1'b1;
        wait_n(8);
        address = 2'd3;
        step();
        check("c_rise2_ec", rd_c, 32'h8000_0001);
        check("d_rise2_ec", rd_d, 32'h0);

        // Reset during a debounce count with edges pending
        in_b = '0;
        wait_n(10);
        write_reg(2'd3, 32'hFFFF_FFFF);
        in_b = 18'hF;
        wait_n(10);
        address = 2'd3;
        step();
        check("pre_rst_ec", rd_b, 32'hF);
        in_b = 18'h1F;
        wait_n(4);
        reset = 1'b1;
        step();
        check("mid_rst_rd", rd_b, 32'h0);
        check("mid_rst_irq", {31'h0, irq_b}, 32'h0);
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("post_rst_ec", rd_b, (k == 8) ? 32'h1F : 32'h0);
        end

        // Randomised traffic checked against the model every cycle
        for (int n = 0; n < 600; n++) begin
            flip = '0;
            if ($urandom_range(0, 2) == 0) flip[$urandom_range(0, 17)] = 1'b1;
            in_b = in_b ^ flip;
            address = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 2) begin
                chipselect = 1'b1;
                write_n    = 1'b0;
                writedata  = $urandom();
            end else begin
                chipselect = 1'($urandom_range(0, 1));
                write_n    = 1'b1;
                writedata  = $urandom();
            end
            reset = ($urandom_range(0, 249) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
